// File: rtl/core_pkg.sv
// Shared load/store unit types: access size encoding, exception causes and the
// completion queue entry layout.
package core_pkg;

    typedef enum logic [1:0] {
        SizeWord = 2'b00,
        SizeHalf = 2'b01,
        SizeByte = 2'b10
    } size_e;

    localparam logic [3:0] CauseLdMisalign = 4'd4;
    localparam logic [3:0] CauseLdFault    = 4'd5;
    localparam logic [3:0] CauseStMisalign = 4'd6;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  dest;
        logic        wb;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] tval;
        logic        sign;
        size_e       size;
        logic [1:0]  off;
    } lsu_entry_t;

endpackage

// File: rtl/mem_lsu_if.sv
// Execute, data-cache and writeback channels of the load/store unit.
interface mem_lsu_if;
    logic        exe_valid_i;
    logic        exe_ready_o;
    logic        exe_load_i;
    logic        exe_store_i;
    logic        exe_sign_i;
    logic        exe_wb_i;
    logic [1:0]  exe_size_i;
    logic [5:0]  exe_dest_i;
    logic [31:0] exe_res_i;
    logic [31:0] exe_data_i;

    logic        dc_req_valid_o;
    logic        dc_req_ready_i;
    logic [31:0] dc_adr_o;
    logic [31:0] dc_wdata_o;
    logic        dc_store_o;
    logic [3:0]  dc_byt_sel_o;
    logic        dc_rsp_valid_i;
    logic [31:0] dc_rsp_data_i;
    logic        dc_rsp_err_i;

    logic        wbk_valid_o;
    logic        wbk_ready_i;
    logic [31:0] wbk_data_o;
    logic [5:0]  wbk_dest_o;
    logic        wbk_wb_o;
    logic        wbk_exc_o;
    logic [3:0]  wbk_cause_o;
    logic [31:0] wbk_tval_o;

    logic        flush_i;

    modport slave (
        input  exe_valid_i, exe_load_i, exe_store_i, exe_sign_i, exe_wb_i,
        input  exe_size_i, exe_dest_i, exe_res_i, exe_data_i,
        output exe_ready_o,
        output dc_req_valid_o, dc_adr_o, dc_wdata_o, dc_store_o, dc_byt_sel_o,
        input  dc_req_ready_i, dc_rsp_valid_i, dc_rsp_data_i, dc_rsp_err_i,
        output wbk_valid_o, wbk_data_o, wbk_dest_o, wbk_wb_o, wbk_exc_o,
        output wbk_cause_o, wbk_tval_o,
        input  wbk_ready_i, flush_i
    );

    modport master (
        output exe_valid_i, exe_load_i, exe_store_i, exe_sign_i, exe_wb_i,
        output exe_size_i, exe_dest_i, exe_res_i, exe_data_i,
        input  exe_ready_o,
        input  dc_req_valid_o, dc_adr_o, dc_wdata_o, dc_store_o, dc_byt_sel_o,
        output dc_req_ready_i, dc_rsp_valid_i, dc_rsp_data_i, dc_rsp_err_i,
        input  wbk_valid_o, wbk_data_o, wbk_dest_o, wbk_wb_o, wbk_exc_o,
        input  wbk_cause_o, wbk_tval_o,
        output wbk_ready_i, flush_i
    );
endinterface

// File: rtl/mem_lsu_queue.sv
// In-order completion queue: entries retire from the head once marked done; loads are
// filled in order by locating the oldest entry still waiting.
module mem_lsu_queue
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       push,
    input  lsu_entry_t push_entry,
    input  logic       push_done,
    input  logic       pop,
    input  logic       fill,
    input  lsu_entry_t fill_entry,
    output logic       full,
    output logic       head_valid,
    output lsu_entry_t head_entry,
    output logic       fill_found,
    output lsu_entry_t fill_cur
);
    localparam int unsigned AW = $clog2(DEPTH);

    lsu_entry_t       entries [DEPTH];
    logic [DEPTH-1:0] done_q;
    logic [AW:0]      wr_ptr_q, rd_ptr_q, count;
    logic [AW-1:0]    fill_idx, scan_idx;

    always_comb begin
        count      = wr_ptr_q - rd_ptr_q;
        full       = (count == (AW+1)'(DEPTH));
        head_entry = entries[rd_ptr_q[AW-1:0]];
        head_valid = (count != '0) && done_q[rd_ptr_q[AW-1:0]];
    end

    // Non-loads are done on entry, so the first not-done slot from the head is the
    // load the next cache response belongs to.
    always_comb begin
        fill_found = 1'b0;
        fill_idx   = '0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q[AW-1:0] + AW'(i);
            if (!fill_found && ((AW+1)'(i) < count) && !done_q[scan_idx]) begin
                fill_found = 1'b1;
                fill_idx   = scan_idx;
            end
        end
        fill_cur = entries[fill_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            done_q   <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            done_q   <= '0;
        end else begin
            if (push) begin
                done_q[wr_ptr_q[AW-1:0]] <= push_done;
                wr_ptr_q                 <= wr_ptr_q + 1'b1;
            end
            if (fill && fill_found) begin
                done_q[fill_idx] <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            entries[wr_ptr_q[AW-1:0]] <= push_entry;
        end
        if (fill && fill_found && !flush) begin
            entries[fill_idx] <= fill_entry;
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: issues aligned accesses to the data cache, tracks outstanding loads
// and returns all ops in program order through the completion queue.
module mem_lsu
    import core_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 2
) (
    input logic       clk,
    input logic       reset_n,
    mem_lsu_if.slave  bus
);
    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    size_e       size;
    logic        mem_op, misaligned, load_block, full, accept, load_issue;
    logic        rsp_dec, rsp_fill, push_done, pop, head_valid, fill_found;
    logic [3:0]  byt_sel;
    logic [31:0] wdata, lane, ld_data;
    logic [CW-1:0] inflight_q, drop_cnt_q;
    lsu_entry_t  push_entry, fill_entry, head_entry, fill_cur;

    always_comb begin
        size       = size_e'(bus.exe_size_i);
        mem_op     = bus.exe_load_i || bus.exe_store_i;
        misaligned = 1'b0;
        byt_sel    = 4'b1111;
        wdata      = bus.exe_data_i;
        case (size)
            SizeByte: begin
                byt_sel = 4'b0001 << bus.exe_res_i[1:0];
                wdata   = {4{bus.exe_data_i[7:0]}};
            end
            SizeHalf: begin
                misaligned = bus.exe_res_i[0];
                byt_sel    = 4'b0011 << bus.exe_res_i[1:0];
                wdata      = {2{bus.exe_data_i[15:0]}};
            end
            default: misaligned = (bus.exe_res_i[1:0] != 2'b00);
        endcase
    end

    assign load_block = bus.exe_load_i && (inflight_q == CW'(MAX_OUT));

    always_comb begin
        bus.exe_ready_o    = !full && !bus.flush_i &&
                             (!mem_op || misaligned || (bus.dc_req_ready_i && !load_block));
        bus.dc_req_valid_o = bus.exe_valid_i && mem_op && !misaligned && !full &&
                             !bus.flush_i && !load_block;
        bus.dc_adr_o       = bus.dc_req_valid_o ? bus.exe_res_i : '0;
        bus.dc_wdata_o     = bus.dc_req_valid_o ? wdata : '0;
        bus.dc_store_o     = bus.dc_req_valid_o && bus.exe_store_i;
        bus.dc_byt_sel_o   = bus.dc_req_valid_o ? byt_sel : '0;
        accept             = bus.exe_valid_i && bus.exe_ready_o;
        load_issue         = bus.dc_req_valid_o && bus.dc_req_ready_i && bus.exe_load_i;
    end

    always_comb begin
        push_entry      = '0;
        push_entry.dest = bus.exe_dest_i;
        push_entry.sign = bus.exe_sign_i;
        push_entry.size = size;
        push_entry.off  = bus.exe_res_i[1:0];
        push_done       = 1'b1;
        if (mem_op && misaligned) begin
            push_entry.exc   = 1'b1;
            push_entry.cause = bus.exe_load_i ? CauseLdMisalign : CauseStMisalign;
            push_entry.tval  = bus.exe_res_i;
        end else if (bus.exe_load_i) begin
            // Address kept in tval so a faulting response can report it.
            push_entry.wb   = bus.exe_wb_i;
            push_entry.tval = bus.exe_res_i;
            push_done       = 1'b0;
        end else if (!bus.exe_store_i) begin
            push_entry.data = bus.exe_res_i;
            push_entry.wb   = bus.exe_wb_i;
        end
    end

    always_comb begin
        lane = bus.dc_rsp_data_i >> {fill_cur.off, 3'b000};
        case (fill_cur.size)
            SizeByte: ld_data = fill_cur.sign ? {{24{lane[7]}}, lane[7:0]}
                                              : {24'b0, lane[7:0]};
            SizeHalf: ld_data = fill_cur.sign ? {{16{lane[15]}}, lane[15:0]}
                                              : {16'b0, lane[15:0]};
            default:  ld_data = lane;
        endcase
        fill_entry = fill_cur;
        if (bus.dc_rsp_err_i) begin
            fill_entry.data  = '0;
            fill_entry.wb    = 1'b0;
            fill_entry.exc   = 1'b1;
            fill_entry.cause = CauseLdFault;
        end else begin
            fill_entry.data = ld_data;
            fill_entry.tval = '0;
        end
        rsp_fill = bus.dc_rsp_valid_i && (drop_cnt_q == '0) && !bus.flush_i;
        rsp_dec  = bus.dc_rsp_valid_i && (inflight_q != '0);
    end

    // inflight counts every request still owed a response, including those to be dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_q + CW'(load_issue) - CW'(rsp_dec);
            if (bus.flush_i) begin
                drop_cnt_q <= inflight_q - CW'(rsp_dec);
            end else if (bus.dc_rsp_valid_i && (drop_cnt_q != '0)) begin
                drop_cnt_q <= drop_cnt_q - CW'(1);
            end
        end
    end

    assign pop = head_valid && bus.wbk_ready_i;

    mem_lsu_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (bus.flush_i),
        .push       (accept),
        .push_entry (push_entry),
        .push_done  (push_done),
        .pop        (pop),
        .fill       (rsp_fill),
        .fill_entry (fill_entry),
        .full       (full),
        .head_valid (head_valid),
        .head_entry (head_entry),
        .fill_found (fill_found),
        .fill_cur   (fill_cur)
    );

    always_comb begin
        bus.wbk_valid_o = head_valid;
        bus.wbk_data_o  = head_valid ? head_entry.data : '0;
        bus.wbk_dest_o  = head_valid ? head_entry.dest : '0;
        bus.wbk_wb_o    = head_valid && head_entry.wb;
        bus.wbk_exc_o   = head_valid && head_entry.exc;
        bus.wbk_cause_o = head_valid ? head_entry.cause : '0;
        bus.wbk_tval_o  = head_valid ? head_entry.tval : '0;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-order completion queue entries (power of 2, >=2).
REQ-002 SHALL have parameter MAX_OUT, default 2, maximum loads awaiting cache response (1..DEPTH).
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports exe_valid_i in 1 / exe_ready_o out 1  exe-side handshake.
REQ-006 SHALL have ports exe_load_i, exe_store_i, exe_sign_i, exe_wb_i  in  1 each  op class, load sign-extend, register writeback.
REQ-007 SHALL have ports exe_size_i in 2 (00 word, 01 half, 10 byte); exe_dest_i in 6; exe_res_i in 32 (address or ALU result); exe_data_i in 32 (store data).
REQ-008 SHALL have ports dc_req_valid_o out 1 / dc_req_ready_i in 1; dc_adr_o out 32; dc_wdata_o out 32; dc_store_o out 1; dc_byt_sel_o out 4.
REQ-009 SHALL have ports dc_rsp_valid_i in 1; dc_rsp_data_i in 32; dc_rsp_err_i in 1  load response, in request order.
REQ-010 SHALL have ports wbk_valid_o out 1 / wbk_ready_i in 1; wbk_data_o out 32; wbk_dest_o out 6; wbk_wb_o out 1; wbk_exc_o out 1; wbk_cause_o out 4; wbk_tval_o out 32.
REQ-011 SHALL have port flush_i  in  1  discard all queued ops.

Function
REQ-012 SHALL accept an op when exe_valid_i && exe_ready_o; exe_ready_o = !queue_full && !flush_i && (!mem_op || misaligned || (dc_req_ready_i && !(load && inflight==MAX_OUT))).
REQ-013 SHALL drive dc_req_valid_o = exe_valid_i && mem_op && !misaligned && !queue_full && !flush_i && !(load && inflight==MAX_OUT); independent of dc_req_ready_i.
REQ-014 SHALL flag misaligned: half with adr[0]=1, word with adr[1:0]!=0; no cache request; entry done with cause 4 (load) / 6 (store), tval=exe_res_i.
REQ-015 SHALL compute byt_sel: byte 0001<<adr[1:0]; half 0011<<adr[1:0]; word 1111.
REQ-016 SHALL replicate store data across lanes: byte {4{b}}, half {2{h}}, word unchanged.
REQ-017 SHALL push every accepted op into the queue; non-load ops done on entry, loads done on response.
REQ-018 SHALL fill the oldest not-done load entry on dc_rsp_valid_i; extract lane per stored offset/size, sign- or zero-extend per exe_sign_i.
REQ-019 SHALL mark load with dc_rsp_err_i as exception cause 5, tval=address, wbk_wb_o=0.
REQ-020 SHALL assert wbk_valid_o when head entry done; pop on wbk_valid_o && wbk_ready_i; outputs held stable while stalled.
REQ-021 SHALL give latency: op accepted cycle N into empty queue -> wbk_valid_o cycle N+1; load response cycle M -> wbk_valid_o cycle M+1 if at head.
REQ-022 SHALL support push and pop in the same cycle when full (exe_ready_o still low on full; no bypass).
REQ-023 SHALL keep inflight counter (0..MAX_OUT): +1 on accepted load request, -1 on response, unchanged if both.
REQ-024 SHALL on flush_i empty queue next cycle, set drop_cnt = inflight minus same-cycle response; responses while drop_cnt>0 decrement and are discarded.
REQ-025 SHALL, flush_i with exe_valid_i same cycle: flush wins, no acceptance, no cache request.
REQ-026 SHALL wrap queue pointers modulo DEPTH with extra bit for full/empty.

Reset
REQ-027 SHALL on reset_n low clear pointers, inflight, drop_cnt, done flags; exe_ready_o per REQ-012 (1 for non-mem); wbk_valid_o=0, dc_req_valid_o=0 only if exe_valid_i=0; all data outputs 0.
REQ-028 SHALL discard responses arriving after reset mid-operation only if drop_cnt>0 (drop_cnt=0 after reset; cache reset jointly).

Structure
REQ-029 SHALL place size encoding, cause codes (4,5,6), and queue entry struct in shared package core_pkg.
REQ-030 SHALL use one sub-module mem_lsu_queue (pointers, entries, done flags); alignment/extension logic in mem_lsu.

Verification
REQ-031 ALU op res=0x1234, dest=5, wb=1 -> wbk cycle+1: data 0x1234, dest 5, exc 0.
REQ-032 LB adr 0x103, sign=1, rsp 0x80FF_0000 -> byt_sel 1000, data 0xFFFF_FF80.
REQ-033 SW adr 0x102 -> no dc request, wbk exc=1 cause 6 tval 0x102.
REQ-034 SB data 0xAB adr 0x1 -> dc_wdata 0xABABABAB, byt_sel 0010, wbk wb=0.
REQ-035 Two loads issued, MAX_OUT=2, third load held (exe_ready_o=0) until first response.
REQ-036 Two loads in flight, flush, then new LW -> first two responses dropped, third returned at wbk.
